pipe_ctrl_unit: RTL

//  Central sequencer for the 5-stage pipeline around the execute stage: load-use stalls, branch/jump redirect

---
 rtl/pipe_ctrl_unit_pkg.sv | 41 ++++
 rtl/pipe_ctrl_unit_hazard_detect.sv | 25 ++
 rtl/pipe_ctrl_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared encodings for the pipeline control unit: FSM states, system-instruction
// kinds, default trap constants and the captured system-instruction payload.
package pipe_ctrl_unit_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  // Sequencer states
  localparam logic [2:0] ST_RUN   = 3'd0;
  localparam logic [2:0] ST_DRAIN = 3'd1;
  localparam logic [2:0] ST_TRAP  = 3'd2;
  localparam logic [2:0] ST_REDIR = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  typedef enum logic [1:0] {
    SYS_ECALL  = 2'd0,
    SYS_MRET   = 2'd1,
    SYS_FENCE  = 2'd2,
    SYS_EBREAK = 2'd3
  } sys_kind_e;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT    = 32'h3000_0000;
  localparam logic [XLEN-1:0] ECALL_CAUSE_DEFAULT = 32'd11;

  // State captured when a system instruction leaves EX
  typedef struct packed {
    sys_kind_e       kind;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] a0;
  } sys_cap_t;

  // Collapse the one-hot-ish system decode; fence is the fallback kind
  function automatic sys_kind_e sys_kind_of(input logic ecall, input logic mret,
                                            input logic ebreak);
    if (ecall)       return SYS_ECALL;
    else if (mret)   return SYS_MRET;
    else if (ebreak) return SYS_EBREAK;
    else             return SYS_FENCE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_unit_hazard_detect.sv
// Load-use hazard comparator: a load in EX whose destination feeds the
// instruction sitting in ID. x0 never creates a hazard.
module pipe_ctrl_unit_hazard_detect
  import pipe_ctrl_unit_pkg::*;
(
  input  logic             ex_valid_i,
  input  logic             ex_mem_ren_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  output logic             load_use_o
);

  logic rd_nonzero;
  logic rd_match;

  // Pure combinational compare of EX destination against ID sources
  always_comb begin
    rd_nonzero = (ex_rd_i != '0);
    rd_match   = (ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i);
    load_use_o = ex_valid_i && ex_mem_ren_i && id_valid_i && rd_nonzero && rd_match;
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control unit: load-use stalls, branch/jump redirect with younger
// stage flush, and multi-cycle ecall/mret/fence/ebreak sequencing.
// Optional feature macro: PIPE_CTRL_PERF_EN (stall/flush performance counters).
module pipe_ctrl_unit
  import pipe_ctrl_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter logic [31:0] ECALL_CAUSE = ECALL_CAUSE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic             ex_valid_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             ex_mem_ren_i,
  input  logic             ex_branch_taken_i,
  input  logic             ex_is_jump_i,
  input  logic [XLEN-1:0]  ex_target_i,
  input  logic [XLEN-1:0]  ex_pc_i,
  input  logic             ex_ecall_i,
  input  logic             ex_mret_i,
  input  logic             ex_ebreak_i,
  input  logic             ex_fence_i,
  input  logic [XLEN-1:0]  ex_a0_i,
  input  logic             mem_busy_i,
  input  logic             wb_busy_i,
  input  logic [XLEN-1:0]  csr_mtvec_i,
  input  logic [XLEN-1:0]  csr_mepc_i,
  output logic             stall_if_o,
  output logic             stall_id_o,
  output logic             flush_if_id_o,
  output logic             flush_id_ex_o,
  output logic             flush_ex_mem_o,
  output logic             redirect_valid_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic             csr_trap_wen_o,
  output logic [XLEN-1:0]  csr_mepc_wdata_o,
  output logic [XLEN-1:0]  csr_mcause_wdata_o,
  output logic             halt_o,
  output logic [XLEN-1:0]  halt_code_o,
  output logic [XLEN-1:0]  perf_stall_cnt_o,
  output logic [XLEN-1:0]  perf_flush_cnt_o
);

  logic [2:0] state_q, state_d;
  sys_cap_t   cap_q, cap_d;
  logic       load_use;
  logic       sys_in_ex;
  logic       redirect_in_ex;

  pipe_ctrl_unit_hazard_detect u_hazard (
    .ex_valid_i   (ex_valid_i),
    .ex_mem_ren_i (ex_mem_ren_i),
    .ex_rd_i      (ex_rd_i),
    .id_valid_i   (id_valid_i),
    .id_rs1_i     (id_rs1_i),
    .id_rs2_i     (id_rs2_i),
    .load_use_o   (load_use)
  );

  assign sys_in_ex      = ex_valid_i && (ex_ecall_i || ex_mret_i || ex_ebreak_i || ex_fence_i);
  assign redirect_in_ex = ex_branch_taken_i || ex_is_jump_i;

  // State and captured system-instruction payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
    end
  end

  // Next-state and same-cycle control outputs; RUN reacts to EX immediately,
  // the system sequence states ignore every ex_* input
  always_comb begin
    state_d            = state_q;
    cap_d              = cap_q;
    stall_if_o         = 1'b0;
    stall_id_o         = 1'b0;
    flush_if_id_o      = 1'b0;
    flush_id_ex_o      = 1'b0;
    flush_ex_mem_o     = 1'b0;
    redirect_valid_o   = 1'b0;
    redirect_pc_o      = RESET_PC;
    csr_trap_wen_o     = 1'b0;
    csr_mepc_wdata_o   = '0;
    csr_mcause_wdata_o = '0;
    halt_o             = 1'b0;
    halt_code_o        = '0;

    case (state_q)
      ST_RUN: begin
        if (sys_in_ex) begin
          cap_d.kind     = sys_kind_of(ex_ecall_i, ex_mret_i, ex_ebreak_i);
          cap_d.pc       = ex_pc_i;
          cap_d.a0       = ex_a0_i;
          stall_if_o     = 1'b1;
          stall_id_o     = 1'b1;
          flush_id_ex_o  = 1'b1;
          flush_ex_mem_o = 1'b1;
          state_d        = ST_DRAIN;
        end else if (redirect_in_ex) begin
          redirect_valid_o = 1'b1;
          redirect_pc_o    = ex_target_i;
          flush_if_id_o    = 1'b1;
          flush_id_ex_o    = 1'b1;
        end else if (load_use) begin
          stall_if_o    = 1'b1;
          stall_id_o    = 1'b1;
          flush_id_ex_o = 1'b1;
        end
      end

      ST_DRAIN: begin
        stall_if_o    = 1'b1;
        stall_id_o    = 1'b1;
        flush_id_ex_o = 1'b1;
        if (!mem_busy_i && !wb_busy_i) begin
          case (cap_q.kind)
            SYS_ECALL:  state_d = ST_TRAP;
            SYS_EBREAK: state_d = ST_HALT;
            default:    state_d = ST_REDIR;
          endcase
        end
      end

      ST_TRAP: begin
        stall_if_o         = 1'b1;
        stall_id_o         = 1'b1;
        flush_id_ex_o      = 1'b1;
        csr_trap_wen_o     = 1'b1;
        csr_mepc_wdata_o   = cap_q.pc;
        csr_mcause_wdata_o = ECALL_CAUSE;
        state_d            = ST_REDIR;
      end

      ST_REDIR: begin
        redirect_valid_o = 1'b1;
        flush_if_id_o    = 1'b1;
        flush_id_ex_o    = 1'b1;
        case (cap_q.kind)
          SYS_ECALL: redirect_pc_o = csr_mtvec_i;
          SYS_MRET:  redirect_pc_o = csr_mepc_i;
          default:   redirect_pc_o = cap_q.pc + 32'd4;
        endcase
        state_d = ST_RUN;
      end

      ST_HALT: begin
        stall_if_o    = 1'b1;
        stall_id_o    = 1'b1;
        flush_id_ex_o = 1'b1;
        halt_o        = 1'b1;
        halt_code_o   = cap_q.a0;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [XLEN-1:0] stall_cnt_q;
  logic [XLEN-1:0] flush_cnt_q;

  // Free-running event counters, wrapping at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + XLEN'(stall_if_o);
      flush_cnt_q <= flush_cnt_q + XLEN'(flush_if_id_o);
    end
  end

  assign perf_stall_cnt_o = stall_cnt_q;
  assign perf_flush_cnt_o = flush_cnt_q;
`else
  assign perf_stall_cnt_o = '0;
  assign perf_flush_cnt_o = '0;
`endif

endmodule
